// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc -- registered multicycle ALU
//
// Purpose:
//   Registered ALU for a multicycle datapath. Logic, add/sub and signed
//   set-less-than return one cycle after start. Unsigned multiply (shift-add,
//   full double-width product) and unsigned divide/remainder (restoring
//   division) iterate one bit per cycle. A start/busy/valid handshake lets
//   the control FSM stall on long operations.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset_n    in   asynchronous active-low reset (synchronous release)
//   start      in   request, sampled on a rising edge while busy=0
//   op[3:0]    in   operation code
//   a, b       in   operands, captured at start
//   y          out  result / low half of product / quotient
//   y_hi       out  high half of product / remainder; 0 for single-cycle ops
//   zero_flag  out  registered y == 0
//   carry_flag out  adder carry-out (ADD/SUB/SLT), else 0
//   ovf_flag   out  signed overflow (ADD/SUB), else 0
//   dz_flag    out  divide by zero (DIVU), else 0
//   busy       out  iterative operation in progress
//   valid      out  one-cycle pulse when results are updated
// ----------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             ovf_flag,
   output logic             dz_flag,
   output logic             busy,
   output logic             valid
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MULU = 4'b0011;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Iteration registers shared by MUL and DIV:
   //   MUL: {hi_reg, lo_reg} is the accumulator/multiplier shift pair,
   //        opnd_reg holds the multiplicand.
   //   DIV: hi_reg is the partial remainder, lo_reg shifts the dividend out
   //        and the quotient in, opnd_reg holds the divisor.
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic [WIDTH-1:0] opnd_reg, opnd_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [WIDTH-1:0] y_next, y_hi_next;
   logic             zero_next, carry_next, ovf_next, dz_next;
   logic             busy_next, valid_next;

   // ------------------------------------------------------------------------
   // Single-cycle unit (combinational on the live operands)
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] and_v, or_v, xor_v, nor_v;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_logic
         assign and_v[gi] = a[gi] & b[gi];
         assign or_v[gi]  = a[gi] | b[gi];
         assign xor_v[gi] = a[gi] ^ b[gi];
         assign nor_v[gi] = ~(a[gi] | b[gi]);
      end
   endgenerate

   logic [WIDTH:0] add_res, sub_res;
   logic           add_ovf, sub_ovf, slt_bit;

   assign add_res = {1'b0, a} + {1'b0, b};
   // Subtraction as a + ~b + 1, so bit WIDTH is the carry (1 = no borrow).
   assign sub_res = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
   // Signed less-than: sign of the difference corrected by overflow.
   assign slt_bit = sub_res[WIDTH-1] ^ sub_ovf;

   logic [WIDTH-1:0] s_y;
   logic             s_carry, s_ovf;

   always_comb begin
      s_y     = '0;
      s_carry = 1'b0;
      s_ovf   = 1'b0;
      case (op)
         OP_AND: s_y = and_v;
         OP_OR:  s_y = or_v;
         OP_XOR: s_y = xor_v;
         OP_NOR: s_y = nor_v;
         OP_ADD: begin
            s_y     = add_res[WIDTH-1:0];
            s_carry = add_res[WIDTH];
            s_ovf   = add_ovf;
         end
         OP_SUB: begin
            s_y     = sub_res[WIDTH-1:0];
            s_carry = sub_res[WIDTH];
            s_ovf   = sub_ovf;
         end
         OP_SLT: begin
            s_y     = {{(WIDTH-1){1'b0}}, slt_bit};
            s_carry = sub_res[WIDTH];
         end
         default: s_y = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Iterative step datapaths
   // ------------------------------------------------------------------------
   // Shift-add multiply: add the multiplicand when the current multiplier bit
   // is set, then shift the {acc, multiplier} pair right by one. The carry of
   // the add becomes the new accumulator MSB.
   logic [WIDTH-1:0] mul_addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   assign mul_addend = lo_reg[0] ? opnd_reg : {WIDTH{1'b0}};
   assign mul_sum    = {1'b0, hi_reg} + {1'b0, mul_addend};
   assign mul_hi     = mul_sum[WIDTH:1];
   assign mul_lo     = {mul_sum[0], lo_reg[WIDTH-1:1]};

   // Restoring divide: shift the next dividend bit into the remainder, try to
   // subtract the divisor, keep the difference only when it did not go
   // negative. The partial remainder is always < divisor, so the kept
   // difference fits in WIDTH bits and modular subtraction is exact.
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] div_hi, div_lo;

   assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd_reg});
   assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
   assign div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
   assign div_lo    = {lo_reg[WIDTH-2:0], div_ge};

   // ------------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      opnd_next  = opnd_reg;
      cnt_next   = cnt_reg;
      y_next     = y;
      y_hi_next  = y_hi;
      zero_next  = zero_flag;
      carry_next = carry_flag;
      ovf_next   = ovf_flag;
      dz_next    = dz_flag;
      busy_next  = busy;
      valid_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MULU) begin
                  opnd_next  = b;
                  lo_next    = a;
                  hi_next    = '0;
                  cnt_next   = CNT_INIT;
                  busy_next  = 1'b1;
                  state_next = S_MUL;
               end else if (op == OP_DIVU) begin
                  if (b == '0) begin
                     // Divide by zero short-circuits without iterating.
                     y_next     = '1;
                     y_hi_next  = a;
                     carry_next = 1'b0;
                     ovf_next   = 1'b0;
                     dz_next    = 1'b1;
                     valid_next = 1'b1;
                  end else begin
                     opnd_next  = b;
                     lo_next    = a;
                     hi_next    = '0;
                     cnt_next   = CNT_INIT;
                     busy_next  = 1'b1;
                     state_next = S_DIV;
                  end
               end else begin
                  y_next     = s_y;
                  y_hi_next  = '0;
                  carry_next = s_carry;
                  ovf_next   = s_ovf;
                  dz_next    = 1'b0;
                  valid_next = 1'b1;
               end
            end
         end

         S_MUL: begin
            hi_next  = mul_hi;
            lo_next  = mul_lo;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
               y_next     = mul_lo;
               y_hi_next  = mul_hi;
               carry_next = 1'b0;
               ovf_next   = 1'b0;
               dz_next    = 1'b0;
               valid_next = 1'b1;
               busy_next  = 1'b0;
               state_next = S_IDLE;
            end
         end

         S_DIV: begin
            hi_next  = div_hi;
            lo_next  = div_lo;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
               y_next     = div_lo;
               y_hi_next  = div_hi;
               carry_next = 1'b0;
               ovf_next   = 1'b0;
               dz_next    = 1'b0;
               valid_next = 1'b1;
               busy_next  = 1'b0;
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
         end
      endcase

      // zero_flag tracks y only and only changes together with the results.
      if (valid_next) begin
         zero_next = (y_next == '0);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= S_IDLE;
         hi_reg     <= '0;
         lo_reg     <= '0;
         opnd_reg   <= '0;
         cnt_reg    <= '0;
         y          <= '0;
         y_hi       <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
         dz_flag    <= 1'b0;
         busy       <= 1'b0;
         valid      <= 1'b0;
      end else begin
         state_reg  <= state_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         opnd_reg   <= opnd_next;
         cnt_reg    <= cnt_next;
         y          <= y_next;
         y_hi       <= y_hi_next;
         zero_flag  <= zero_next;
         carry_flag <= carry_next;
         ovf_flag   <= ovf_next;
         dz_flag    <= dz_next;
         busy       <= busy_next;
         valid      <= valid_next;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ----------------------------------------------------------------------------
// tb_alu_mc -- scoreboard testbench for alu_mc (WIDTH=8)
//
// Stimulus pushes the hand-computed expected result of every accepted request
// into a queue; a monitor pops and compares whenever valid is seen.
// ----------------------------------------------------------------------------
module tb_alu_mc;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   op = 4'b0000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] y, y_hi;
   logic         zero_flag, carry_flag, ovf_flag, dz_flag, busy, valid;

   alu_mc #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .y          (y),
      .y_hi       (y_hi),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .ovf_flag   (ovf_flag),
      .dz_flag    (dz_flag),
      .busy       (busy),
      .valid      (valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [W-1:0] y;
      logic [W-1:0] y_hi;
      logic         z, c, o, d;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (reset_n && valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1 y=0x%0h, expected no result", y);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".y"},     32'(y),          32'(e.y));
            check({e.name, ".y_hi"},  32'(y_hi),       32'(e.y_hi));
            check({e.name, ".zero"},  32'(zero_flag),  32'(e.z));
            check({e.name, ".carry"}, 32'(carry_flag), 32'(e.c));
            check({e.name, ".ovf"},   32'(ovf_flag),   32'(e.o));
            check({e.name, ".dz"},    32'(dz_flag),    32'(e.d));
            $display("[%0t] %-10s y=0x%02h y_hi=0x%02h z=%0b c=%0b o=%0b dz=%0b",
                     $time, e.name, y, y_hi, zero_flag, carry_flag, ovf_flag, dz_flag);
         end
      end
   end

   // Issue one request (caller is at a negedge), wait for valid with a bound,
   // and check latency in edges and the number of busy cycles. Optionally
   // pulse an ADD start three cycles in, which must be ignored.
   task automatic run(input string nm, input logic [3:0] o_in, input logic [W-1:0] a_in,
                      input logic [W-1:0] b_in, input logic [W-1:0] ey, input logic [W-1:0] eh,
                      input logic ez, input logic ec, input logic eo, input logic ed,
                      input int e_edges, input int e_busy, input bit poke);
      exp_t e;
      int   edges;
      int   busy_cnt;
      e.name = nm; e.y = ey; e.y_hi = eh; e.z = ez; e.c = ec; e.o = eo; e.d = ed;
      exp_q.push_back(e);
      op    = o_in;
      a     = a_in;
      b     = b_in;
      start = 1'b1;
      edges    = 0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         edges++;
         start = 1'b0;
         if (busy) busy_cnt++;
         if (poke && edges == 3) begin
            op    = 4'b0010;
            a     = 8'h01;
            b     = 8'h01;
            start = 1'b1;
         end
      end while (!valid && edges < 40);
      start = 1'b0;
      check({nm, ".latency"}, 32'(edges), 32'(e_edges));
      check({nm, ".busy_cycles"}, 32'(busy_cnt), 32'(e_busy));
   endtask

   initial begin
      int vcount;

      // Reset state
      #1;
      check("reset.y", 32'(y), 32'h0);
      check("reset.y_hi", 32'(y_hi), 32'h0);
      check("reset.busy", 32'(busy), 32'h0);
      check("reset.valid", 32'(valid), 32'h0);
      check("reset.flags", 32'({zero_flag, carry_flag, ovf_flag, dz_flag}), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle.no_valid", 32'(valid), 32'h0);
      check("idle.zero_flag", 32'(zero_flag), 32'h0);

      //   name         op       a      b      y      y_hi   z     c     o     dz    edg busy poke
      run("add_ovf",   4'b0010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0);
      @(negedge clk);
      run("sub_eq",    4'b0110, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0);
      @(negedge clk);
      run("sub_borrow",4'b0110, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      @(negedge clk);
      run("slt_neg",   4'b0111, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
      @(negedge clk);
      run("and",       4'b0000, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      run("or",        4'b0001, 8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      run("xor",       4'b1000, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      run("nor",       4'b1001, 8'hF0, 8'h3C, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      run("undef_op",  4'b0101, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      @(negedge clk);
      run("mulu_200x3",4'b0011, 8'd200, 8'd3, 8'h58, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 9, 8, 1);
      @(negedge clk);
      run("divu_100_7",4'b0100, 8'd100, 8'd7, 8'd14, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 9, 8, 0);
      @(negedge clk);
      run("divu_dz",   4'b0100, 8'd9,  8'd0,  8'hFF, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0);
      @(negedge clk);
      run("divu_7_9",  4'b0100, 8'd7,  8'd9,  8'h00, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 9, 8, 0);
      @(negedge clk);
      run("mulu_ffxff",4'b0011, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 9, 8, 0);
      @(negedge clk);
      // Back-to-back: ADD issued in the cycle MULU's valid is high
      run("mulu_13x11",4'b0011, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9, 8, 0);
      run("add_b2b",   4'b0010, 8'd1,  8'd1,  8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      @(negedge clk);
      check("hold.y", 32'(y), 32'h02);
      check("hold.valid_low", 32'(valid), 32'h0);

      // Reset three cycles into a DIVU
      op    = 4'b0100;
      a     = 8'd100;
      b     = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort.busy_before", 32'(busy), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort.busy", 32'(busy), 32'h0);
      check("abort.valid", 32'(valid), 32'h0);
      check("abort.y", 32'(y), 32'h0);
      check("abort.y_hi", 32'(y_hi), 32'h0);
      check("abort.flags", 32'({zero_flag, carry_flag, ovf_flag, dz_flag}), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (valid) vcount++;
      end
      check("abort.no_stale_valid", 32'(vcount), 32'h0);
      check("abort.no_busy", 32'(busy), 32'h0);

      run("add_after", 4'b0010, 8'd2, 8'd3, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
